uart_line_buffer: RTL
=====================

# uart_line_buffer

Parametrised line-editing receive buffer between the osdvu `uart` core and a `bram` instance in the b1 top level. Stores received characters in a power-of-two ring buffer with full/empty tracking, echoes input with CR→CRLF, backspace editing and BEL on error, and on the replay character transmits and consumes one buffered line. Replaces the fixed-size, overflow-blind echo/dump state machine in the top level.

## Interface
- `ADDR_WIDTH`, 8: ring depth is 2^ADDR_WIDTH bytes; addresses `mem_addr` directly.
- `REPLAY_CHAR`, 8'h60: received byte that triggers line replay; never stored.
- `ECHO_EN`, 1: 1 = echo stored bytes; 0 = echo only CRLF, backspace sequence and BEL.
- `CLK` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: one-cycle strobe, `rx_byte` valid (uart `received`).
- `rx_byte` in 8: received byte.
- `tx_busy` in 1: uart `is_transmitting`.
- `transmit` out 1: one-cycle transmit strobe.
- `tx_byte` out 8: byte to send; stable from strobe until `tx_busy` falls.
- `mem_cs_n`, `mem_wr_n`, `mem_rd_n` out 1 each: active-low bram controls.
- `mem_addr` out ADDR_WIDTH: bram address.
- `mem_wdata` out 8 / `mem_rdata` in 8: bram data; read data valid the cycle after `mem_rd_n` low.
- `count` out ADDR_WIDTH+1: bytes stored (terminators included).
- `full`, `empty` out 1: `count == 2^ADDR_WIDTH`, `count == 0`.
- `overflow` out 1: sticky, byte dropped because buffer full.
- `overrun` out 1: sticky, `rx_valid` seen while not IDLE.
- `flag_clr` in 1: synchronous clear of both sticky flags.
- `busy` out 1: state != IDLE.

## Operation
- Pointers `wr_ptr`, `rd_ptr` are ADDR_WIDTH+1 bits; address = low ADDR_WIDTH bits; wrap naturally; `count = wr_ptr - rd_ptr`. `line_len` (ADDR_WIDTH+1) counts bytes since last terminator.
- States: IDLE, STORE, TX, TX_WAIT, RD_REQ, RD_DATA.
- IDLE, `rx_valid`, classify `rx_byte`:
  - 0x0D: if !full → STORE 8'h00 terminator, `line_len`←0, queue 0D 0A; else queue 07, set overflow.
  - 0x08: if `line_len`>0 → `wr_ptr`−1, `line_len`−1, queue 08 20 08 (no memory cycle); else queue 07.
  - REPLAY_CHAR: if !empty → RD_REQ; else queue 07.
  - other: if !full → STORE byte, `line_len`+1, queue byte if ECHO_EN; else queue 07, set overflow.
- STORE: one cycle, `mem_cs_n`=`mem_wr_n`=0, addr=`wr_ptr`; `wr_ptr`+1; then TX (or IDLE if queue empty).
- TX: when !tx_busy, `transmit`=1 with head of queue (≤3 bytes) → TX_WAIT. TX_WAIT: ignore first cycle, then on !tx_busy pop; next byte → TX, queue empty → return state (IDLE or RD_REQ).
- Replay: RD_REQ `mem_cs_n`=`mem_rd_n`=0, addr=`rd_ptr`; RD_DATA captures `mem_rdata`, `rd_ptr`+1. Nonzero → queue byte, return RD_REQ if still !empty else IDLE. Zero → queue 0D 0A, return IDLE. If rd consumes the current unterminated line, `line_len` clamps to `count`.
- `rx_valid` outside IDLE: byte dropped, `overrun` set. `rx_valid` and `flag_clr` same cycle: set wins.

## Timing
- Reset: state IDLE, pointers/line_len 0, `transmit` 0, `tx_byte` 0, mem controls 1, `mem_addr`/`mem_wdata` 0, `overflow`/`overrun` 0, `empty` 1, `full` 0, `busy` 0. Reset mid-transfer aborts immediately; buffer contents are discarded logically.
- `rx_valid`→write strobe: 1 cycle; →first `transmit`: 2 cycles if tx idle.
- Replay: byte from RD_REQ to `transmit` ≥3 cycles.
- `count`/`full`/`empty` update the cycle after the pointer change; registered outputs.

## Structure
- `b1_uart_defs.vh`: state encodings, char constants (CR, LF, BS, SP, BEL, NUL).
- Sub-module `uart_tx_seq`: 3-entry byte queue plus transmit/busy handshake (TX/TX_WAIT).
- `bram` instantiated at top level, not inside.

## Test plan
- Rx 'A','B',CR with ADDR_WIDTH=2 → mem writes 41,42,00 at 0,1,2; tx 41 42 0D 0A; count 3.
- Fill 4 bytes at ADDR_WIDTH=2, rx 'E' → no write, tx 07, full=1, overflow=1; flag_clr clears overflow.
- Rx 'A','B',BS,'C',CR → memory 41,43,00; tx 41 42 08 20 08 43 0D 0A; BS on empty line → tx 07.
- Store "HI"+CR, rx 0x60 → tx 48 49 0D 0A, 0x60 not stored, count 0, empty=1; second 0x60 → tx 07.
- Rx byte while TX_WAIT → dropped, overrun=1, buffer unchanged.
- Pointer wrap: 6 store/replay cycles at ADDR_WIDTH=2 → addresses wrap 3→0, data correct; reset_n low mid-replay → all outputs at reset values next cycle.

Source files
------------

// File: rtl/uart_line_buffer_pkg.sv
// Shared state encodings, character constants and the small transmit-queue record
// used by the line buffer and its transmit sequencer.
package uart_line_buffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STORE,
    ST_TX,
    ST_TX_WAIT,
    ST_RD_REQ,
    ST_RD_DATA
  } state_e;

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_BEL = 8'h07;
  localparam logic [7:0] CH_NUL = 8'h00;

  // Up to three bytes to send; dat[0] goes out first.
  typedef struct packed {
    logic [1:0]      cnt;
    logic [2:0][7:0] dat;
  } txq_t;

  function automatic txq_t txq(input logic [1:0] n, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2);
    txq_t r;
    r.cnt = n;
    r.dat = {b2, b1, b0};
    return r;
  endfunction

endpackage

// File: rtl/uart_line_buffer_if.sv
// Bundle of the uart, bram and status signals around the line buffer.
// master = the line buffer, slave = the surrounding top level / uart / bram.
interface uart_line_buffer_if #(parameter int ADDR_WIDTH = 8);
  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic                  tx_busy;
  logic                  transmit;
  logic [7:0]            tx_byte;
  logic                  mem_cs_n;
  logic                  mem_wr_n;
  logic                  mem_rd_n;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  overrun;
  logic                  flag_clr;
  logic                  busy;

  modport master (
    input  rx_valid, rx_byte, tx_busy, mem_rdata, flag_clr,
    output transmit, tx_byte, mem_cs_n, mem_wr_n, mem_rd_n, mem_addr, mem_wdata,
           count, full, empty, overflow, overrun, busy
  );

  modport slave (
    output rx_valid, rx_byte, tx_busy, mem_rdata, flag_clr,
    input  transmit, tx_byte, mem_cs_n, mem_wr_n, mem_rd_n, mem_addr, mem_wdata,
           count, full, empty, overflow, overrun, busy
  );
endinterface

// File: rtl/uart_line_buffer_tx_seq.sv
// Three-byte transmit queue feeding the uart: one-cycle transmit strobe per byte,
// waits for the uart busy flag to rise and fall before sending the next byte.
module uart_line_buffer_tx_seq
  import uart_line_buffer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  txq_t       load_dat_i,
  input  logic       tx_busy_i,
  output logic       transmit_o,
  output logic [7:0] tx_byte_o,
  output logic       idle_o
);

  state_e     state_q;
  txq_t       q_q;
  logic       first_q;
  logic       transmit_q;
  logic [7:0] tx_byte_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      q_q        <= '0;
      first_q    <= 1'b0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      transmit_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_i && load_dat_i.cnt != 2'd0) begin
            q_q     <= load_dat_i;
            state_q <= ST_TX;
          end
        end
        ST_TX: begin
          if (!tx_busy_i) begin
            transmit_q <= 1'b1;
            tx_byte_q  <= q_q.dat[0];
            first_q    <= 1'b1;
            state_q    <= ST_TX_WAIT;
          end
        end
        ST_TX_WAIT: begin
          // The uart raises its busy flag one cycle after the strobe, so skip that cycle.
          if (first_q) begin
            first_q <= 1'b0;
          end else if (!tx_busy_i) begin
            q_q.dat <= {CH_NUL, q_q.dat[2:1]};
            q_q.cnt <= q_q.cnt - 2'd1;
            state_q <= (q_q.cnt > 2'd1) ? ST_TX : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign transmit_o = transmit_q;
  assign tx_byte_o  = tx_byte_q;
  assign idle_o     = (state_q == ST_IDLE);

endmodule

// File: rtl/uart_line_buffer.sv
// Line-editing ring buffer between the uart and a bram: echo with CR->CRLF, backspace
// and BEL, replay of one stored line on REPLAY_CHAR. Write strobe 1 cycle after rx_valid.
module uart_line_buffer
  import uart_line_buffer_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 8,
  parameter logic [7:0] REPLAY_CHAR = 8'h60,
  parameter bit         ECHO_EN     = 1'b1
) (
  input  logic                CLK,
  input  logic                reset_n,
  uart_line_buffer_if.master  bus
);

  localparam int            PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] ONE   = PW'(1);

  state_e                state_q, ret_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q, line_len_q, count_q;
  logic                  full_q, empty_q, overflow_q, overrun_q;
  logic                  mem_cs_n_q, mem_wr_n_q, mem_rd_n_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [7:0]            mem_wdata_q;

  logic [PW-1:0] cnt, cnt_rd;
  logic          is_full, is_empty;
  logic          q_load, seq_idle;
  txq_t          q_new;

  // Decisions use the live pointer difference; the registered copies lag a cycle.
  assign cnt      = wr_ptr_q - rd_ptr_q;
  assign cnt_rd   = cnt - ONE;
  assign is_full  = (cnt == DEPTH);
  assign is_empty = (cnt == '0);

  always_comb begin
    q_load = 1'b0;
    q_new  = txq(2'd1, CH_BEL, CH_NUL, CH_NUL);
    if (state_q == ST_IDLE && bus.rx_valid) begin
      q_load = 1'b1;
      if (bus.rx_byte == CH_CR) begin
        if (!is_full) q_new = txq(2'd2, CH_CR, CH_LF, CH_NUL);
      end else if (bus.rx_byte == CH_BS) begin
        if (line_len_q != '0) q_new = txq(2'd3, CH_BS, CH_SP, CH_BS);
      end else if (bus.rx_byte == REPLAY_CHAR) begin
        if (!is_empty) q_load = 1'b0;
      end else if (!is_full) begin
        q_load = ECHO_EN;
        q_new  = txq(2'd1, bus.rx_byte, CH_NUL, CH_NUL);
      end
    end else if (state_q == ST_RD_DATA) begin
      q_load = 1'b1;
      q_new  = (bus.mem_rdata == CH_NUL) ? txq(2'd2, CH_CR, CH_LF, CH_NUL)
                                         : txq(2'd1, bus.mem_rdata, CH_NUL, CH_NUL);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      line_len_q  <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      overrun_q   <= 1'b0;
      mem_cs_n_q  <= 1'b1;
      mem_wr_n_q  <= 1'b1;
      mem_rd_n_q  <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
    end else begin
      mem_cs_n_q <= 1'b1;
      mem_wr_n_q <= 1'b1;
      mem_rd_n_q <= 1'b1;
      count_q    <= cnt;
      full_q     <= is_full;
      empty_q    <= is_empty;
      if (bus.flag_clr) begin
        overflow_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
      if (bus.rx_valid && state_q != ST_IDLE) overrun_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (bus.rx_valid) begin
            ret_q   <= ST_IDLE;
            state_q <= ST_TX;
            if (bus.rx_byte == CH_BS) begin
              if (line_len_q != '0) begin
                wr_ptr_q   <= wr_ptr_q - ONE;
                line_len_q <= line_len_q - ONE;
              end
            end else if (bus.rx_byte == REPLAY_CHAR) begin
              if (!is_empty) begin
                state_q    <= ST_RD_REQ;
                mem_cs_n_q <= 1'b0;
                mem_rd_n_q <= 1'b0;
                mem_addr_q <= rd_ptr_q[ADDR_WIDTH-1:0];
              end
            end else if (is_full) begin
              overflow_q <= 1'b1;
            end else begin
              state_q     <= ST_STORE;
              mem_cs_n_q  <= 1'b0;
              mem_wr_n_q  <= 1'b0;
              mem_addr_q  <= wr_ptr_q[ADDR_WIDTH-1:0];
              mem_wdata_q <= (bus.rx_byte == CH_CR) ? CH_NUL : bus.rx_byte;
              line_len_q  <= (bus.rx_byte == CH_CR) ? '0 : line_len_q + ONE;
            end
          end
        end
        ST_STORE: begin
          wr_ptr_q <= wr_ptr_q + ONE;
          state_q  <= seq_idle ? ST_IDLE : ST_TX;
        end
        ST_TX: begin
          if (seq_idle) begin
            state_q <= ret_q;
            if (ret_q == ST_RD_REQ) begin
              mem_cs_n_q <= 1'b0;
              mem_rd_n_q <= 1'b0;
              mem_addr_q <= rd_ptr_q[ADDR_WIDTH-1:0];
            end
          end
        end
        ST_RD_REQ: state_q <= ST_RD_DATA;
        ST_RD_DATA: begin
          rd_ptr_q <= rd_ptr_q + ONE;
          // Reading into an unterminated line shortens what backspace may erase.
          if (line_len_q > cnt_rd) line_len_q <= cnt_rd;
          ret_q   <= (bus.mem_rdata != CH_NUL && cnt_rd != '0) ? ST_RD_REQ : ST_IDLE;
          state_q <= ST_TX;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  uart_line_buffer_tx_seq u_tx_seq (
    .clk_i      (CLK),
    .rst_ni     (reset_n),
    .load_i     (q_load),
    .load_dat_i (q_new),
    .tx_busy_i  (bus.tx_busy),
    .transmit_o (bus.transmit),
    .tx_byte_o  (bus.tx_byte),
    .idle_o     (seq_idle)
  );

  assign bus.mem_cs_n  = mem_cs_n_q;
  assign bus.mem_wr_n  = mem_wr_n_q;
  assign bus.mem_rd_n  = mem_rd_n_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.overflow  = overflow_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
